cla_bist_driver: RTL and testbench
==================================

Name: cla_bist_driver

Overview:
Built-in self-test driver/checker for the registered carry-lookahead adder top level. It is the opposite end of the adder's operand/result interface: it generates every x/y/cin combination, drives them into the adder, and checks the returned z/cout against an internal golden sum. The checker realigns the golden sum to the adder's registered latency. It sits beside the adder in the top level and reports pass/fail and error statistics to a test controller.

Parameters:
WIDTH, 4, operand width of x, y and z.
LAT, 1, adder result latency in clk cycles; legal range 1..4.
ERRW, 10, width of the saturating error counter.

Ports:
clk  in  1  system clock, rising edge.
res  in  1  reset; asynchronous assert, active-low.
start  in  1  one-cycle pulse that begins a sweep; ignored while busy=1.
dut_x  out  WIDTH  operand x to the adder.
dut_y  out  WIDTH  operand y to the adder.
dut_cin  out  1  carry-in to the adder.
dut_z  in  WIDTH  sum returned by the adder.
dut_cout  in  1  carry-out returned by the adder.
busy  out  1  high while in RUN or DRAIN.
done  out  1  high from sweep completion until the next accepted start.
pass  out  1  done=1 and err_cnt=0.
err_cnt  out  ERRW  number of mismatching vectors; saturates at all-ones.
first_fail  out  2*WIDTH+1  vector index of the first mismatch; valid when err_cnt!=0.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE. All outputs 0, vector counter 0, expect pipeline cleared, valid bits 0.
- Vector index V is 2*WIDTH+1 bits. Mapping: dut_x=V[WIDTH-1:0], dut_y=V[2*WIDTH-1:WIDTH], dut_cin=V[2*WIDTH]. There are NVEC=2^(2*WIDTH+1) vectors; NVEC=512 at WIDTH=4.
- Operand outputs are registered and change only on clk. Outside RUN they hold 0.
- Golden sum E={cout,z}=x+y+cin, WIDTH+1 bits, no truncation.
- E and V enter a LAT-deep shift pipeline together, with a valid bit, in the cycle the vector is driven. They are compared against {dut_cout,dut_z} LAT cycles later.
- FSM states:
  - IDLE: start -> RUN. On entry to RUN, clear V, err_cnt, first_fail and done; drive vector 0.
  - RUN: each cycle drive V, then V+1. After driving V=NVEC-1 -> DRAIN. V does not wrap into a second sweep.
  - DRAIN: hold operands at 0, valid-in 0. After LAT cycles -> DONE.
  - DONE: done=1, busy=0. start -> RUN, restarting the sweep. Otherwise stay.
- Compare rule: when the pipeline output valid=1 and the returned value differs from the delayed E:
  - increment err_cnt unless it is already all-ones;
  - if err_cnt was 0 before this increment, load first_fail with the delayed V.
- Timing: done rises exactly NVEC+LAT+1 cycles after the start pulse is sampled.
- Simultaneous events:
  - start during RUN or DRAIN is ignored.
  - start in the same cycle res deasserts is ignored; the first start is sampled on the next edge.
- Reset mid-sweep aborts immediately to IDLE with all outputs 0. No partial result is kept.
- The block does not drive the adder's own reset. The system holds the adder out of reset before start.

Decomposition:
- Shared package cla_bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - function nvec(WIDTH);
  - localparam VW=2*WIDTH+1.
- One sub-module, cla_expect_pipe. It computes E and delays {valid, V, E} by LAT stages, with asynchronous active-low clear on res.
- The FSM, counters and comparator stay in cla_bist_driver.

Test Plan:
- Golden behavioural adder model with LAT=1, start at cycle 10 -> busy 1 for 513 cycles, done=1 at cycle 524, pass=1, err_cnt=0.
- Model with z[0] stuck at 0 -> err_cnt=256, first_fail=1 (x=1,y=0,cin=0), pass=0.
- Model with cout stuck at 0 -> err_cnt=256, first_fail=31 (x=15,y=1,cin=0).
- ERRW=4 with the z[0] stuck-at-0 fault -> err_cnt saturates at 15, first_fail=1, no wrap to 0.
- res driven low at cycle 100 of a sweep -> same-cycle busy=0, dut_x/dut_y/dut_cin=0, err_cnt=0. A new start after release completes with pass=1.
- LAT=3 with a model delayed 3 cycles -> pass=1, done NVEC+4 cycles after start. Start pulses during RUN are ignored: V and err_cnt are unaffected.

Source files
------------

// File: rtl/cla_bist_pkg.sv
// Shared types and sizing helpers for the carry-lookahead adder BIST driver.
// The sweep covers every {cin, y, x} combination of a WIDTH-bit adder.
package cla_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DEF_WIDTH = 4;

    function automatic int vec_width(input int width);
        return 2 * width + 1;
    endfunction

    function automatic longint nvec(input int width);
        return longint'(1) << vec_width(width);
    endfunction

    localparam int VW = vec_width(DEF_WIDTH);

endpackage

// File: rtl/cla_bist_if.sv
// Operand/result bus between the BIST driver (master) and the adder (slave).
interface cla_bist_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH-1:0] z;
    logic             cout;

    modport master (output x, y, cin, input z, cout);
    modport slave  (input x, y, cin, output z, cout);

endinterface

// File: rtl/cla_expect_pipe.sv
// Golden-sum generator plus a LAT-deep delay line that realigns {valid, vector, sum}
// with the adder's registered result.
module cla_expect_pipe
    import cla_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = 1,
    localparam int VECW = vec_width(WIDTH)
) (
    input  logic            clk,
    input  logic            res,
    input  logic            valid_in,
    input  logic [VECW-1:0] vec_in,
    output logic            valid_out,
    output logic [VECW-1:0] vec_out,
    output logic [WIDTH:0]  exp_out
);

    logic [WIDTH:0]  sum_in;
    logic            valid_q [LAT];
    logic [VECW-1:0] vec_q   [LAT];
    logic [WIDTH:0]  exp_q   [LAT];

    // Full-width sum so a lost carry-out is caught as well as a bad sum bit.
    assign sum_in = {1'b0, vec_in[WIDTH-1:0]}
                  + {1'b0, vec_in[2*WIDTH-1:WIDTH]}
                  + {{WIDTH{1'b0}}, vec_in[2*WIDTH]};

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                vec_q[i]   <= '0;
                exp_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= valid_in;
            vec_q[0]   <= vec_in;
            exp_q[0]   <= sum_in;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                vec_q[i]   <= vec_q[i-1];
                exp_q[i]   <= exp_q[i-1];
            end
        end
    end

    assign valid_out = valid_q[LAT-1];
    assign vec_out   = vec_q[LAT-1];
    assign exp_out   = exp_q[LAT-1];

endmodule

// File: rtl/cla_bist_driver.sv
// Exhaustive BIST driver/checker for a registered carry-lookahead adder: sweeps all
// operand/carry combinations once per start and counts mismatching results.
module cla_bist_driver
    import cla_bist_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = 1,
    parameter int ERRW  = 10
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    cla_bist_if.master        dut,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERRW-1:0]   err_cnt,
    output logic [2*WIDTH:0]  first_fail
);

    localparam int VECW = vec_width(WIDTH);
    localparam logic [VECW-1:0] LAST_VEC = VECW'(nvec(WIDTH) - 1);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_END = DW'(LAT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [VECW-1:0] vec;
    logic [VECW-1:0] vec_nxt;
    logic [DW-1:0]   drain_cnt;
    logic [DW-1:0]   drain_nxt;
    logic            done_nxt;
    logic            armed;
    logic            accept;
    logic            pipe_valid;
    logic [VECW-1:0] pipe_vec;
    logic [WIDTH:0]  pipe_exp;
    logic            mismatch;

    // armed stays low for the first edge after reset so a start overlapping release is dropped.
    assign accept = start && armed && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            vec       <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            vec       <= vec_nxt;
            drain_cnt <= drain_nxt;
            done      <= done_nxt;
            armed     <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        drain_nxt = drain_cnt;
        done_nxt  = done;
        unique case (state)
            IDLE, DONE: begin
                if (state == DONE) done_nxt = 1'b1;
                if (accept) begin
                    state_nxt = RUN;
                    vec_nxt   = '0;
                    done_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (vec == LAST_VEC) begin
                    state_nxt = DRAIN;
                    vec_nxt   = '0;
                    drain_nxt = '0;
                end else begin
                    vec_nxt = vec + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_END) state_nxt = DONE;
                else                        drain_nxt = drain_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dut.x   = vec[WIDTH-1:0];
    assign dut.y   = vec[2*WIDTH-1:WIDTH];
    assign dut.cin = vec[2*WIDTH];
    assign busy    = (state == RUN) || (state == DRAIN);
    assign pass    = done && (err_cnt == '0);

    cla_expect_pipe #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) u_expect (
        .clk       (clk),
        .res       (res),
        .valid_in  (state == RUN),
        .vec_in    (vec),
        .valid_out (pipe_valid),
        .vec_out   (pipe_vec),
        .exp_out   (pipe_exp)
    );

    assign mismatch = pipe_valid && ({dut.cout, dut.z} != pipe_exp);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            err_cnt    <= '0;
            first_fail <= '0;
        end else if (accept) begin
            err_cnt    <= '0;
            first_fail <= '0;
        end else if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_fail <= pipe_vec;
        end
    end

endmodule

// File: tb/tb_cla_bist_driver.sv
// Runs three BIST drivers (LAT=1/ERRW=10, LAT=1/ERRW=4, LAT=3/ERRW=10) against
// behavioural adders with planted stuck-at faults and checks against a sweep model.
module tb_cla_bist_driver;
    import cla_bist_pkg::*;

    localparam int WIDTH = 4;
    localparam int NV    = int'(nvec(WIDTH));
    localparam int LAT2  = 3;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic [2:0]       start = '0;
    logic [2:0]       busy;
    logic [2:0]       done;
    logic [2:0]       pass;
    logic [9:0]       err0;
    logic [3:0]       err1;
    logic [9:0]       err2;
    logic [VW-1:0]    ff0;
    logic [VW-1:0]    ff1;
    logic [VW-1:0]    ff2;
    int               fault_bit [3];
    int               fault_val [3];
    int               compared   = 0;
    int               mismatched = 0;

    cla_bist_if #(.WIDTH(WIDTH)) bus0 ();
    cla_bist_if #(.WIDTH(WIDTH)) bus1 ();
    cla_bist_if #(.WIDTH(WIDTH)) bus2 ();

    cla_bist_driver #(.WIDTH(WIDTH), .LAT(1), .ERRW(10)) dut0 (
        .clk(clk), .res(res), .start(start[0]), .dut(bus0), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_cnt(err0), .first_fail(ff0));
    cla_bist_driver #(.WIDTH(WIDTH), .LAT(1), .ERRW(4)) dut1 (
        .clk(clk), .res(res), .start(start[1]), .dut(bus1), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_cnt(err1), .first_fail(ff1));
    cla_bist_driver #(.WIDTH(WIDTH), .LAT(LAT2), .ERRW(10)) dut2 (
        .clk(clk), .res(res), .start(start[2]), .dut(bus2), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_cnt(err2), .first_fail(ff2));

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] faultySum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic c, input int fb, input int fv);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        if (fb >= 0) s[fb] = fv[0];
        return s;
    endfunction

    // Behavioural adders: registered results, one with a three-cycle latency.
    logic [WIDTH:0] add0_q;
    logic [WIDTH:0] add1_q;
    logic [WIDTH:0] add2_q [LAT2];

    always @(posedge clk) begin
        add0_q    <= faultySum(bus0.x, bus0.y, bus0.cin, fault_bit[0], fault_val[0]);
        add1_q    <= faultySum(bus1.x, bus1.y, bus1.cin, fault_bit[1], fault_val[1]);
        add2_q[0] <= faultySum(bus2.x, bus2.y, bus2.cin, fault_bit[2], fault_val[2]);
        for (int i = 1; i < LAT2; i++) add2_q[i] <= add2_q[i-1];
    end

    assign {bus0.cout, bus0.z} = add0_q;
    assign {bus1.cout, bus1.z} = add1_q;
    assign {bus2.cout, bus2.z} = add2_q[LAT2-1];

    function automatic int latOf(input int i);
        return (i == 2) ? LAT2 : 1;
    endfunction

    function automatic int errwOf(input int i);
        return (i == 1) ? 4 : 10;
    endfunction

    function automatic int errOf(input int i);
        case (i)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

    function automatic int ffOf(input int i);
        case (i)
            0:       return int'(ff0);
            1:       return int'(ff1);
            default: return int'(ff2);
        endcase
    endfunction

    function automatic int opsOf(input int i);
        case (i)
            0:       return int'({bus0.cin, bus0.y, bus0.x});
            1:       return int'({bus1.cin, bus1.y, bus1.x});
            default: return int'({bus2.cin, bus2.y, bus2.x});
        endcase
    endfunction

    // Whole-sweep reference: walk every vector with plain arithmetic and tally faulty results.
    function automatic void refSweep(input int fb, input int fv, input int errw,
                                     output int cnt, output int first);
        int base, a, b, c, s, f;
        base  = 1 << WIDTH;
        cnt   = 0;
        first = 0;
        for (int v = 0; v < NV; v++) begin
            a = v % base;
            b = (v / base) % base;
            c = v / (base * base);
            s = a + b + c;
            f = s;
            if (fb >= 0) f = (fv != 0) ? (s | (1 << fb)) : (s & ~(1 << fb));
            if (f != s) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
        if (cnt > (1 << errw) - 1) cnt = (1 << errw) - 1;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One full sweep on all three drivers, with a start pulse injected mid-RUN that must be ignored.
    task automatic applyStimulus(input int ignore_at, input int spot_at);
        int done_at [3];
        int busy_n  [3];
        int n, cnt, first;
        for (int i = 0; i < 3; i++) begin
            done_at[i] = -1;
            busy_n[i]  = 0;
        end
        start = 3'b111;
        @(posedge clk); #1;
        start = 3'b000;
        n = 0;
        forever begin
            for (int i = 0; i < 3; i++) begin
                if (busy[i]) busy_n[i]++;
                if (done[i] && done_at[i] < 0) done_at[i] = n;
                if (n == spot_at) checkOutput($sformatf("inst%0d operands", i), opsOf(i), n);
            end
            if ((done_at[0] >= 0 && done_at[1] >= 0 && done_at[2] >= 0) || n > NV + 20) break;
            start = (n == ignore_at) ? 3'b111 : 3'b000;
            @(posedge clk); #1;
            n++;
        end
        start = 3'b000;
        for (int i = 0; i < 3; i++) begin
            refSweep(fault_bit[i], fault_val[i], errwOf(i), cnt, first);
            checkOutput($sformatf("inst%0d done_latency", i), done_at[i], NV + latOf(i) + 1);
            checkOutput($sformatf("inst%0d busy_cycles", i), busy_n[i], NV + latOf(i));
            checkOutput($sformatf("inst%0d err_cnt", i), errOf(i), cnt);
            checkOutput($sformatf("inst%0d first_fail", i), ffOf(i), first);
            checkOutput($sformatf("inst%0d pass", i), int'(pass[i]), (cnt == 0) ? 1 : 0);
            checkOutput($sformatf("inst%0d idle_operands", i), opsOf(i), 0);
        end
    endtask

    initial begin
        fault_bit = '{-1, -1, -1};
        fault_val = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("inst%0d reset busy", i), int'(busy[i]), 0);
            checkOutput($sformatf("inst%0d reset done", i), int'(done[i]), 0);
            checkOutput($sformatf("inst%0d reset err_cnt", i), errOf(i), 0);
            checkOutput($sformatf("inst%0d reset operands", i), opsOf(i), 0);
        end

        res   = 1'b1;
        start = 3'b111;
        @(posedge clk); #1;
        start = 3'b000;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("inst%0d start_on_release busy", i), int'(busy[i]), 0);
        repeat (6) @(posedge clk);
        #1;

        $display("[TB] sweep 1: z[0] stuck-at-0 on inst0/inst1, clean LAT=3 adder");
        fault_bit = '{0, 0, -1};
        fault_val = '{0, 0, 0};
        applyStimulus(int'($urandom_range(5, 200)), int'($urandom_range(201, 500)));

        $display("[TB] sweep 2: cout stuck-at-0 on inst0, random faults elsewhere");
        fault_bit[0] = WIDTH;
        fault_val[0] = 0;
        for (int i = 1; i < 3; i++) begin
            fault_bit[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, WIDTH));
            fault_val[i] = int'($urandom_range(0, 1));
        end
        applyStimulus(int'($urandom_range(5, 200)), int'($urandom_range(201, 500)));

        $display("[TB] sweep 3: reset asserted mid-sweep");
        fault_bit = '{0, 0, 0};
        fault_val = '{0, 0, 0};
        start = 3'b111;
        @(posedge clk); #1;
        start = 3'b000;
        repeat (100) @(posedge clk);
        #1;
        res = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("inst%0d abort busy", i), int'(busy[i]), 0);
            checkOutput($sformatf("inst%0d abort operands", i), opsOf(i), 0);
            checkOutput($sformatf("inst%0d abort err_cnt", i), errOf(i), 0);
            checkOutput($sformatf("inst%0d abort done", i), int'(done[i]), 0);
        end
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        fault_bit = '{-1, -1, -1};
        applyStimulus(int'($urandom_range(5, 200)), int'($urandom_range(201, 500)));

        $display("[TB] sweep 4: random stuck-at faults on all instances");
        for (int i = 0; i < 3; i++) begin
            fault_bit[i] = int'($urandom_range(0, WIDTH));
            fault_val[i] = int'($urandom_range(0, 1));
        end
        applyStimulus(int'($urandom_range(5, 200)), int'($urandom_range(201, 500)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
